// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// pipeline_types / if_stage_if
//
// Purpose: shared IF->ID payload type and the bus interface that bundles every
// handshake signal of the instruction-fetch stage.
//
// Interface signals (direction as seen by the fetch stage, modport master):
//   imem_req_valid_o  out  1   fetch request valid
//   imem_req_ready_i  in   1   memory accepts request
//   imem_req_addr_o   out  32  word-aligned fetch address
//   imem_rsp_valid_i  in   1   instruction data returned (in order, no stall)
//   imem_rsp_data_i   in   32  instruction word
//   if_id_o           out  96  {pc, pc4, instruction}
//   if_id_valid_o     out  1   if_id_o holds a valid instruction
//   id_ready_i        in   1   decode accepts if_id_o
//   redirect_i        in   1   restart fetch (branch, jump, trap)
//   redirect_pc_i     in   32  restart address, low two bits ignored
// The slave modport is the mirror image, used by the memory/decode side.
// ---------------------------------------------------------------------------
package pipeline_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instruction;
  } if_id_t;
endpackage

interface if_stage_if;
  import pipeline_types::*;

  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  if_id_t      if_id_o;
  logic        if_id_valid_o;
  logic        id_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, if_id_o, if_id_valid_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  id_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, if_id_o, if_id_valid_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output id_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues word-aligned fetch requests from a PC register, remembers the PC of
// every outstanding request in a tag FIFO, pairs returning instruction words
// with their PCs and queues the result for decode. A redirect flushes all
// queued and in-flight work; responses to flushed requests still arrive and
// are swallowed by a drop counter.
//
// Ports:
//   clk   in   single clock, rising edge
//   nrst  in   synchronous active-low reset
//   bus   if_stage_if.master  memory request/response, IF->ID and redirect
// Parameters:
//   RESET_PC      first fetch address after reset (word aligned)
//   MAX_INFLIGHT  limit on outstanding requests + queued instructions
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT = 2
) (
  input logic        clk,
  input logic        nrst,
  if_stage_if.master bus
);
  import pipeline_types::*;

  localparam int            CW    = $clog2(3 * MAX_INFLIGHT + 1);
  localparam int            IW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_INFLIGHT);
  localparam logic [IW-1:0] LAST  = IW'(MAX_INFLIGHT - 1);

  logic          r_active;
  logic [31:0]   r_pc;
  logic [31:0]   r_tagMem [MAX_INFLIGHT];
  logic [IW-1:0] r_tagRd;
  logic [IW-1:0] r_tagWr;
  logic [CW-1:0] r_tagCnt;
  if_id_t        r_qMem [MAX_INFLIGHT];
  logic [IW-1:0] r_qRd;
  logic [IW-1:0] r_qWr;
  logic [CW-1:0] r_qCnt;
  logic [CW-1:0] r_drop;

  logic          w_ifIdValid;
  logic          w_outPop;
  logic [CW-1:0] w_occ;
  logic          w_reqValid;
  logic          w_reqFire;
  logic          w_rspDrop;
  logic          w_rspKeep;
  logic          w_rspStray;
  logic [31:0]   w_tagHead;
  if_id_t        w_newEntry;
  logic [1:0]    w_unusedPcBits;

  function automatic logic [IW-1:0] nextPtr(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_ifIdValid = (r_qCnt != '0) && !bus.redirect_i;
  assign w_outPop    = w_ifIdValid && bus.id_ready_i;

  // An entry leaving the queue this cycle frees its slot for a new request;
  // without this the stage could not stream one instruction per cycle.
  assign w_occ      = r_tagCnt + r_qCnt + r_drop - CW'(w_outPop);
  assign w_reqValid = r_active && !bus.redirect_i && (w_occ < LIMIT);
  assign w_reqFire  = w_reqValid && bus.imem_req_ready_i;

  // Responses go first to pending drops, then to the tag FIFO; one with
  // nothing outstanding at all is stray and ignored.
  assign w_rspDrop  = bus.imem_rsp_valid_i && (r_drop != '0);
  assign w_rspStray = bus.imem_rsp_valid_i && (r_drop == '0) && (r_tagCnt == '0);
  assign w_rspKeep  = bus.imem_rsp_valid_i && (r_drop == '0) && (r_tagCnt != '0)
                      && !bus.redirect_i;

  assign w_tagHead  = r_tagMem[r_tagRd];
  assign w_newEntry = {w_tagHead, w_tagHead + 32'd4, bus.imem_rsp_data_i};

  assign w_unusedPcBits = bus.redirect_pc_i[1:0];

  assign bus.imem_req_valid_o = w_reqValid;
  assign bus.imem_req_addr_o  = r_pc;
  assign bus.if_id_o          = r_qMem[r_qRd];
  assign bus.if_id_valid_o    = w_ifIdValid;

  // r_active holds off the first request until the cycle after reset release.
  // A redirect flushes everything and converts whatever is still outstanding
  // into drops, minus a response that lands in the same cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_active <= 1'b0;
      r_pc     <= RESET_PC;
      r_tagRd  <= '0;
      r_tagWr  <= '0;
      r_tagCnt <= '0;
      r_qRd    <= '0;
      r_qWr    <= '0;
      r_qCnt   <= '0;
      r_drop   <= '0;
    end else begin
      r_active <= 1'b1;
      if (bus.redirect_i) begin
        r_pc     <= {bus.redirect_pc_i[31:2], 2'b00};
        r_tagRd  <= '0;
        r_tagWr  <= '0;
        r_tagCnt <= '0;
        r_qRd    <= '0;
        r_qWr    <= '0;
        r_qCnt   <= '0;
        r_drop   <= r_tagCnt + r_drop - CW'(bus.imem_rsp_valid_i && !w_rspStray);
      end else begin
        if (w_reqFire) begin
          r_pc    <= r_pc + 32'd4;
          r_tagWr <= nextPtr(r_tagWr);
        end
        if (w_rspKeep) begin
          r_tagRd <= nextPtr(r_tagRd);
          r_qWr   <= nextPtr(r_qWr);
        end
        if (w_outPop) begin
          r_qRd <= nextPtr(r_qRd);
        end
        if (w_rspDrop) begin
          r_drop <= r_drop - 1'b1;
        end
        r_tagCnt <= r_tagCnt + CW'(w_reqFire) - CW'(w_rspKeep);
        r_qCnt   <= r_qCnt + CW'(w_rspKeep) - CW'(w_outPop);
      end
    end
  end

  // Storage arrays need no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_reqFire) begin
      r_tagMem[r_tagWr] <= r_pc;
    end
    if (w_rspKeep) begin
      r_qMem[r_qWr] <= w_newEntry;
    end
  end

  // A response with no outstanding request indicates a broken memory model.
  always_ff @(posedge clk) begin
    if (nrst) begin
      assert (!w_rspStray);
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// A small memory model answers requests after a programmable latency with
// data derived from the address. Every accepted request pushes its expected
// IF->ID record onto a scoreboard; every decode-side transfer pops and
// compares it. Redirects and resets clear the scoreboard, so any late
// response leaking through shows up as a data mismatch.
// ---------------------------------------------------------------------------
module tb_if_stage;
  import pipeline_types::*;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  logic clk = 1'b0;
  logic nrst;

  if_stage_if bus();

  if_stage #(
    .RESET_PC     (32'h0000_0000),
    .MAX_INFLIGHT (2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  pend_t  pendQ[$];
  if_id_t sbQ[$];
  if_id_t popLog[$];
  int     testCount = 0;
  int     failCount = 0;
  int     cycleNo   = 0;
  int     memLat    = 1;
  int     lastDue   = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  // One comparison: counts it, and on mismatch reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [95:0] obs,
                             input logic [95:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one clock cycle with the current inputs: samples handshakes before
  // the edge, updates scoreboard and memory model after it, ends at negedge.
  task automatic applyStimulus();
    logic        fire;
    logic        pop;
    logic        redir;
    logic        rst;
    logic [31:0] addr;
    if_id_t      popVal;
    if_id_t      e;
    pend_t       p;
    int          d;
    #1;
    fire   = bus.imem_req_valid_o && bus.imem_req_ready_i;
    addr   = bus.imem_req_addr_o;
    pop    = bus.if_id_valid_o && bus.id_ready_i;
    popVal = bus.if_id_o;
    redir  = bus.redirect_i;
    rst    = !nrst;
    if (pop && !rst) begin
      popLog.push_back(popVal);
      if (sbQ.size() == 0) begin
        checkOutput("popWithEmptyScoreboard", 96'(pop), 96'(0));
      end else begin
        checkOutput("popData", popVal, sbQ.pop_front());
      end
    end
    @(posedge clk);
    cycleNo++;
    if (rst) begin
      pendQ.delete();
      sbQ.delete();
    end else if (redir) begin
      sbQ.delete();
    end else if (fire) begin
      e.pc          = addr;
      e.pc4         = addr + 32'd4;
      e.instruction = memData(addr);
      sbQ.push_back(e);
      d = cycleNo + memLat - 1;
      if (d <= lastDue) d = lastDue + 1;
      lastDue = d;
      p.due   = d;
      p.addr  = addr;
      pendQ.push_back(p);
    end
    #1;
    if (pendQ.size() != 0 && pendQ[0].due == cycleNo) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = memData(pendQ[0].addr);
      void'(pendQ.pop_front());
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
    end
    @(negedge clk);
  endtask

  task automatic waitForPops(input int target, input string tag);
    int k;
    k = 0;
    while (popLog.size() < target && k < 50) begin
      applyStimulus();
      k++;
    end
    checkOutput(tag, 96'(popLog.size()), 96'(target));
  endtask

  task automatic redirectTo(input logic [31:0] target);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = target;
    #1;
    checkOutput("redirectNoReq", 96'(bus.imem_req_valid_o), 96'(0));
    checkOutput("redirectNoOut", 96'(bus.if_id_valid_o), 96'(0));
    applyStimulus();
    bus.redirect_i = 1'b0;
  endtask

  initial begin
    int n0;
    nrst                 = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.id_ready_i       = 1'b1;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    @(negedge clk);

    // Reset state
    repeat (3) applyStimulus();
    #1;
    checkOutput("resetReqValid", 96'(bus.imem_req_valid_o), 96'(0));
    checkOutput("resetOutValid", 96'(bus.if_id_valid_o), 96'(0));

    // Start-up latency and streaming
    nrst = 1'b1;
    #1;
    checkOutput("releaseCycleReqValid", 96'(bus.imem_req_valid_o), 96'(0));
    applyStimulus();
    #1;
    checkOutput("firstReqValid", 96'(bus.imem_req_valid_o), 96'(1));
    checkOutput("firstReqAddr", 96'(bus.imem_req_addr_o), 96'(32'h0));
    applyStimulus();
    #1;
    checkOutput("secondReqAddr", 96'(bus.imem_req_addr_o), 96'(32'h4));
    checkOutput("noEarlyOutput", 96'(bus.if_id_valid_o), 96'(0));
    applyStimulus();
    #1;
    checkOutput("firstOutValid", 96'(bus.if_id_valid_o), 96'(1));
    checkOutput("firstOutData", bus.if_id_o, {32'h0, 32'h4, 32'h13});
    n0 = popLog.size();
    repeat (8) applyStimulus();
    checkOutput("streamRate", 96'(popLog.size() - n0), 96'(8));

    // Fill the queue, then reset mid-stream
    bus.id_ready_i = 1'b0;
    repeat (3) applyStimulus();
    #1;
    checkOutput("fullQueueReqValid", 96'(bus.imem_req_valid_o), 96'(0));
    checkOutput("fullQueueOutValid", 96'(bus.if_id_valid_o), 96'(1));
    nrst = 1'b0;
    applyStimulus();
    #1;
    checkOutput("midResetReqValid", 96'(bus.imem_req_valid_o), 96'(0));
    checkOutput("midResetOutValid", 96'(bus.if_id_valid_o), 96'(0));
    nrst = 1'b1;
    applyStimulus();
    #1;
    checkOutput("restartReqValid", 96'(bus.imem_req_valid_o), 96'(1));
    checkOutput("restartAddr", 96'(bus.imem_req_addr_o), 96'(32'h0));

    // Decode stalled: queue fills, output holds the pc 0x0 record
    repeat (5) applyStimulus();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stallHoldValid", 96'(bus.if_id_valid_o), 96'(1));
      checkOutput("stallHoldData", bus.if_id_o, {32'h0, 32'h4, 32'h13});
      checkOutput("stallNoReq", 96'(bus.imem_req_valid_o), 96'(0));
      applyStimulus();
    end
    bus.id_ready_i = 1'b1;
    n0 = popLog.size();
    repeat (2) applyStimulus();
    checkOutput("stallReleaseCount", 96'(popLog.size()), 96'(n0 + 2));
    if (popLog.size() >= n0 + 2) begin
      checkOutput("stallReleasePc0", 96'(popLog[n0].pc), 96'(32'h0));
      checkOutput("stallReleasePc1", 96'(popLog[n0 + 1].pc), 96'(32'h4));
    end

    // Redirect with slow memory so two responses are outstanding
    memLat = 3;
    repeat (6) applyStimulus();
    n0 = popLog.size();
    redirectTo(32'h0000_0100);
    memLat = 1;
    waitForPops(n0 + 1, "redirect100Timeout");
    if (popLog.size() > n0) begin
      checkOutput("redirect100Out", popLog[n0],
                  {32'h100, 32'h104, memData(32'h100)});
    end

    // Misaligned redirect target is forced to a word boundary
    redirectTo(32'h0000_0203);
    #1;
    checkOutput("redirectAlignAddr", 96'(bus.imem_req_addr_o), 96'(32'h200));
    n0 = popLog.size();
    waitForPops(n0 + 1, "redirect200Timeout");
    if (popLog.size() > n0) begin
      checkOutput("redirect200Pc", 96'(popLog[n0].pc), 96'(32'h200));
    end

    // PC wrap at the top of the address space
    n0 = popLog.size();
    redirectTo(32'hFFFF_FFFC);
    waitForPops(n0 + 2, "wrapTimeout");
    if (popLog.size() >= n0 + 2) begin
      checkOutput("wrapFirst", popLog[n0],
                  {32'hFFFF_FFFC, 32'h0, memData(32'hFFFF_FFFC)});
      checkOutput("wrapSecond", popLog[n0 + 1],
                  {32'h0, 32'h4, memData(32'h0)});
    end

    // Back-to-back redirects: the last one wins
    n0 = popLog.size();
    redirectTo(32'h0000_0300);
    redirectTo(32'h0000_0400);
    #1;
    checkOutput("backToBackAddr", 96'(bus.imem_req_addr_o), 96'(32'h400));
    waitForPops(n0 + 1, "backToBackTimeout");
    if (popLog.size() > n0) begin
      checkOutput("backToBackPc", 96'(popLog[n0].pc), 96'(32'h400));
    end
    repeat (4) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 Parameter MAX_INFLIGHT, default 2, SHALL be the combined limit on outstanding requests plus queued outputs.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 nrst  input  1  SHALL be the synchronous, active-low reset.
REQ-005 imem_req_valid_o  output  1  SHALL flag a fetch request.
REQ-006 imem_req_ready_i  input  1  SHALL flag memory acceptance; a request transfers when valid and ready are both high.
REQ-007 imem_req_addr_o  output  32  SHALL be the word-aligned fetch address.
REQ-008 imem_rsp_valid_i  input  1  SHALL flag returned instruction data; there is no back-pressure, and responses return in order.
REQ-009 imem_rsp_data_i  input  32  SHALL be the instruction word.
REQ-010 if_id_o  output  96  SHALL be pipeline_types::if_id_t {pc, pc4, instruction}.
REQ-011 if_id_valid_o  output  1  SHALL flag that if_id_o holds a valid fetched instruction.
REQ-012 id_ready_i  input  1  SHALL flag decode acceptance; a transfer occurs when valid and ready are both high.
REQ-013 redirect_i  input  1  SHALL request a fetch restart (branch, jump or trap).
REQ-014 redirect_pc_i  input  32  SHALL be the restart address; bits [1:0] SHALL be ignored and treated as zero.

Function
REQ-015 The block SHALL hold a fetch PC register (pc_q), an in-flight tag FIFO of request PCs (depth MAX_INFLIGHT), an output queue of if_id_t (depth MAX_INFLIGHT), and a drop counter.
REQ-016 imem_req_valid_o SHALL equal (!redirect_i && inflight + queued + drop < MAX_INFLIGHT), where inflight counts only non-dropped outstanding requests.
REQ-017 imem_req_addr_o SHALL equal pc_q.
REQ-018 On request transfer, pc_q SHALL advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000), and the old pc_q SHALL be pushed into the tag FIFO.
REQ-019 On a response while drop > 0, the response SHALL be discarded and drop decremented.
REQ-020 On a response while drop == 0, the block SHALL pop the tag FIFO and push {pc, pc+4 (wrapping), data} into the output queue, visible on if_id_o from the next cycle (a minimum of 1 cycle from response to output).
REQ-021 if_id_o SHALL present the queue head, and if_id_valid_o SHALL be high whenever the queue is non-empty and redirect_i is low.
REQ-022 The queue head SHALL pop on (if_id_valid_o && id_ready_i); push and pop SHALL be allowed in the same cycle.
REQ-023 While id_ready_i is low, if_id_o and if_id_valid_o SHALL hold stable.
REQ-024 When redirect_i is high:
- the output queue SHALL be cleared;
- pc_q SHALL load {redirect_pc_i[31:2], 2'b00};
- all tag FIFO entries SHALL be cleared;
- drop SHALL load the current outstanding count (non-dropped inflight plus existing drop), less one if a response arrives that cycle;
- any response arriving that cycle SHALL be discarded;
- no request SHALL be issued that cycle.
REQ-025 Back-to-back redirects SHALL each apply; the last one SHALL determine pc_q.
REQ-026 With id_ready_i held high and memory replying in one cycle, the block SHALL sustain one instruction per cycle with MAX_INFLIGHT = 2.
REQ-027 imem_rsp_valid_i with no outstanding request SHALL be ignored and SHALL be flagged by a simulation-only assertion.

Reset
REQ-028 While nrst is low at a clock edge:
- pc_q SHALL be RESET_PC;
- the queue, tag FIFO and drop counter SHALL be emptied/zeroed;
- imem_req_valid_o and if_id_valid_o SHALL be 0.
REQ-029 Reset SHALL abandon outstanding requests without tracking them; the memory system SHALL be reset concurrently.
REQ-030 The first request SHALL be presented the cycle after nrst deasserts, with address RESET_PC.

Verification
REQ-031 Release reset, ready=1, one-cycle memory returning 0x00000013 -> requests at 0x0, 0x4, 0x8…; if_id_o {0x0, 0x4, 0x13} valid 2 cycles after the first request; 1 instruction per cycle thereafter.
REQ-032 Hold id_ready_i=0 for 5 cycles with the memory responding -> the queue fills to 2, imem_req_valid_o drops, if_id_o stays at pc 0x0; on ready=1, pcs 0x0 and 0x4 emerge in order with no loss.
REQ-033 Redirect to 0x100 with 2 responses outstanding -> both late responses are discarded, no queued instruction is output, and the next output is pc 0x100, pc4 0x104.
REQ-034 Redirect to 0x203 -> the next request address is 0x200.
REQ-035 Redirect to 0xFFFFFFFC -> output pc 0xFFFFFFFC with pc4 0x00000000, then pc 0x00000000.
REQ-036 Assert nrst low mid-stream with a full queue -> both valids are 0 the next cycle; after release, the fetch restarts at RESET_PC.
